// File: rtl/gfx_pkg.sv
// gfx_pkg: shared constants and types for the graphics pipeline.
//   nfw_state_t      - state encoding of the next-frame pixel writer
//   FRAME_W/FRAME_H  - visible frame size in pixels
//   TRANSPARENT      - colour index that is never written
//   BG_COLOR         - background colour index
//   SRAM_IDLE_ADDR   - address driven while the SRAM bus is not in use
//   nibble_expand()  - turns a 4-bit pixel mask into a 16-bit word mask
package gfx_pkg;

  typedef enum logic [2:0] {
    NFW_IDLE    = 3'd0,
    NFW_PEND    = 3'd1,
    NFW_RD      = 3'd2,
    NFW_RD_CAP  = 3'd3,
    NFW_WR      = 3'd4,
    NFW_WR_HOLD = 3'd5
  } nfw_state_t;

  localparam logic [9:0]  FRAME_W        = 10'd640;
  localparam logic [9:0]  FRAME_H        = 10'd480;
  localparam logic [3:0]  TRANSPARENT    = 4'h0;
  localparam logic [3:0]  BG_COLOR       = 4'h1;
  localparam logic [19:0] SRAM_IDLE_ADDR = 20'h0;

  function automatic logic [15:0] nibble_expand(input logic [3:0] mask);
    for (int i = 0; i < 4; i++) begin
      nibble_expand[4*i +: 4] = {4{mask[i]}};
    end
  endfunction

endpackage

// File: rtl/pixel_word_merge.sv
// pixel_word_merge: combinational nibble merge of two 16-bit SRAM words.
//   base_word  in 16 : word supplying the nibbles outside the mask
//   mask       in  4 : one bit per 4-bit pixel, 1 = take from pend_data
//   pend_data  in 16 : word supplying the nibbles inside the mask
//   merged     out 16: (base_word & ~M) | (pend_data & M), M = expanded mask
module pixel_word_merge
  import gfx_pkg::*;
(
  input  logic [15:0] base_word,
  input  logic [3:0]  mask,
  input  logic [15:0] pend_data,
  output logic [15:0] merged
);

  logic [15:0] word_mask;

  assign word_mask = nibble_expand(mask);
  assign merged    = (base_word & ~word_mask) | (pend_data & word_mask);

endmodule

// File: rtl/next_frame_writer.sv
// next_frame_writer: coalescing pixel-write engine for the next-frame buffer.
// Pixels that land in the same 16-bit SRAM word (4 x 4-bit colour) are merged
// into one pending word, which is committed by read-modify-write, or by a plain
// write when all four nibbles are covered.
//   Clk, Reset                  : clock, synchronous active-high reset
//   EN                          : bus grant; low freezes the block
//   even_frame                  : displayed buffer; writes go to ~even_frame
//   px_valid/px_ready           : pixel request handshake
//   px_x, px_y, px_color        : pixel position and palette index (0 = transparent)
//   flush_req/flush_done        : commit pending word / done (level)
//   step_done                   : safe point for the accelerator to drop EN
//   Data_to_SRAM, Data_from_SRAM: SRAM write / read data
//   SRAM_WE_N, SRAM_OE_N        : active-low write / output enable
//   SRAM_ADDRESS                : SRAM word address
module next_frame_writer
  import gfx_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic        EN,
  input  logic        even_frame,
  input  logic        px_valid,
  output logic        px_ready,
  input  logic [9:0]  px_x,
  input  logic [9:0]  px_y,
  input  logic [3:0]  px_color,
  input  logic        flush_req,
  output logic        flush_done,
  output logic        step_done,
  output logic [15:0] Data_to_SRAM,
  input  logic [15:0] Data_from_SRAM,
  output logic        SRAM_WE_N,
  output logic        SRAM_OE_N,
  output logic [19:0] SRAM_ADDRESS
);

  nfw_state_t  state, state_nxt, commit_state;
  logic [19:0] pend_addr;
  logic [15:0] pend_data;
  logic [3:0]  pend_mask;
  logic [15:0] merged_wr;

  logic [19:0] px_addr;
  logic [3:0]  px_onehot;
  logic        px_drop, px_hit, px_take;
  logic [15:0] hit_word, rd_word;
  logic        oe_n, we_n;
  logic [19:0] addr;
  logic [15:0] wdata;

  assign px_addr   = {1'b0, ~even_frame, px_y, px_x[9:2]};
  assign px_onehot = 4'b0001 << px_x[1:0];
  assign px_drop   = (px_color == TRANSPARENT) || (px_x >= FRAME_W) || (px_y >= FRAME_H);
  assign px_hit    = (px_addr == pend_addr);
  assign px_take   = px_valid & px_ready & ~px_drop;

  // A fully covered word needs no read-back.
  assign commit_state = (pend_mask == 4'hF) ? NFW_WR : NFW_RD;

  // New pixel colour replicated across the word; the one-hot mask picks its nibble.
  pixel_word_merge u_hit_merge (
    .base_word (pend_data),
    .mask      (px_onehot),
    .pend_data ({4{px_color}}),
    .merged    (hit_word)
  );

  pixel_word_merge u_rd_merge (
    .base_word (Data_from_SRAM),
    .mask      (pend_mask),
    .pend_data (pend_data),
    .merged    (rd_word)
  );

  always_comb begin
    state_nxt  = state;
    px_ready   = 1'b0;
    flush_done = 1'b0;
    step_done  = 1'b1;
    oe_n       = 1'b1;
    we_n       = 1'b1;
    addr       = SRAM_IDLE_ADDR;
    wdata      = 16'h0;
    case (state)
      NFW_IDLE: begin
        if (flush_req) begin
          flush_done = 1'b1;
        end else begin
          px_ready = EN;
          if (EN && px_valid && !px_drop) state_nxt = NFW_PEND;
        end
      end
      NFW_PEND: begin
        px_ready = EN & ~flush_req & (px_hit | px_drop);
        if (EN && (flush_req || (px_valid && !px_drop && !px_hit))) state_nxt = commit_state;
      end
      NFW_RD: begin
        step_done = 1'b0;
        oe_n      = 1'b0;
        addr      = pend_addr;
        if (EN) state_nxt = NFW_RD_CAP;
      end
      NFW_RD_CAP: begin
        step_done = 1'b0;
        oe_n      = 1'b0;
        addr      = pend_addr;
        if (EN) state_nxt = NFW_WR;
      end
      NFW_WR: begin
        step_done = 1'b0;
        we_n      = 1'b0;
        addr      = pend_addr;
        wdata     = merged_wr;
        if (EN) state_nxt = NFW_WR_HOLD;
      end
      NFW_WR_HOLD: begin
        // WE_N already released here; the external synchroniser stretches the pulse.
        step_done = 1'b0;
        addr      = pend_addr;
        wdata     = merged_wr;
        if (EN) state_nxt = NFW_IDLE;
      end
      default: state_nxt = NFW_IDLE;
    endcase
    if (Reset) begin
      px_ready   = 1'b0;
      flush_done = 1'b0;
      step_done  = 1'b1;
    end
  end

  // Bus outputs are parked whenever the grant is away or Reset is asserted.
  assign SRAM_OE_N    = (EN && !Reset) ? oe_n  : 1'b1;
  assign SRAM_WE_N    = (EN && !Reset) ? we_n  : 1'b1;
  assign SRAM_ADDRESS = (EN && !Reset) ? addr  : SRAM_IDLE_ADDR;
  assign Data_to_SRAM = (EN && !Reset) ? wdata : 16'h0;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= NFW_IDLE;
      pend_mask <= 4'h0;
    end else begin
      state <= state_nxt;
      if (px_take) begin
        pend_mask <= (state == NFW_IDLE) ? px_onehot : (pend_mask | px_onehot);
      end else if (EN && state == NFW_WR_HOLD) begin
        pend_mask <= 4'h0;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (px_take) begin
      pend_data <= hit_word;
      if (state == NFW_IDLE) pend_addr <= px_addr;
    end
    if (EN && state == NFW_PEND && state_nxt == NFW_WR) begin
      merged_wr <= pend_data;
    end else if (EN && state == NFW_RD_CAP) begin
      merged_wr <= rd_word;
    end
  end

endmodule

// File: tb/tb_next_frame_writer.sv
// tb_next_frame_writer: directed and randomized checks of next_frame_writer
// against an SRAM model and a pixel-level image reference.
module tb_next_frame_writer;

  logic        Clk = 1'b0;
  logic        Reset, EN, even_frame, px_valid, flush_req;
  logic [9:0]  px_x, px_y;
  logic [3:0]  px_color;
  logic        px_ready, flush_done, step_done, SRAM_WE_N, SRAM_OE_N;
  logic [15:0] Data_to_SRAM, Data_from_SRAM;
  logic [19:0] SRAM_ADDRESS;

  int compared   = 0;
  int mismatched = 0;

  // Bus-side SRAM contents (written by the DUT) and reference image words.
  logic [15:0] sram  [logic [19:0]];
  logic [15:0] model [logic [19:0]];

  int          wr_cnt = 0, rd_cnt = 0, sd_low_cnt = 0;
  logic [19:0] last_wr_addr = '0, last_rd_addr = '0;
  logic [15:0] last_wr_data = '0;

  always #5 Clk = ~Clk;

  next_frame_writer dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .EN             (EN),
    .even_frame     (even_frame),
    .px_valid       (px_valid),
    .px_ready       (px_ready),
    .px_x           (px_x),
    .px_y           (px_y),
    .px_color       (px_color),
    .flush_req      (flush_req),
    .flush_done     (flush_done),
    .step_done      (step_done),
    .Data_to_SRAM   (Data_to_SRAM),
    .Data_from_SRAM (Data_from_SRAM),
    .SRAM_WE_N      (SRAM_WE_N),
    .SRAM_OE_N      (SRAM_OE_N),
    .SRAM_ADDRESS   (SRAM_ADDRESS)
  );

  // SRAM model: unwritten words read as background fill, one-cycle read latency.
  always @(posedge Clk) begin
    if (!SRAM_WE_N) begin
      sram[SRAM_ADDRESS] = Data_to_SRAM;
      wr_cnt++;
      last_wr_addr = SRAM_ADDRESS;
      last_wr_data = Data_to_SRAM;
    end
    if (!SRAM_OE_N) begin
      rd_cnt++;
      last_rd_addr = SRAM_ADDRESS;
    end
    if (!step_done) sd_low_cnt++;
    Data_from_SRAM <= sram.exists(SRAM_ADDRESS) ? sram[SRAM_ADDRESS] : 16'h1111;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Reference: a visible, non-transparent pixel sets its nibble of the image word.
  task automatic model_apply(input logic [9:0] x, input logic [9:0] y, input logic [3:0] c,
                             input logic ef);
    logic [19:0] a;
    logic [15:0] w;
    if (c != 4'h0 && x < 10'd640 && y < 10'd480) begin
      a = {1'b0, ~ef, y, x[9:2]};
      w = model.exists(a) ? model[a] : 16'h1111;
      w[4*x[1:0] +: 4] = c;
      model[a] = w;
    end
  endtask

  task automatic send_px(input logic [9:0] x, input logic [9:0] y, input logic [3:0] c,
                         output int waits, output int busy);
    logic acc;
    acc = 1'b0; waits = 0; busy = 0;
    px_x = x; px_y = y; px_color = c; px_valid = 1'b1;
    for (int i = 0; i < 40 && !acc; i++) begin
      @(negedge Clk);
      if (px_ready) acc = 1'b1;
      else begin
        waits++;
        if (!step_done) busy++;
      end
      @(posedge Clk);
      #1;
    end
    px_valid = 1'b0;
    chk("px_accepted", acc, 1'b1);
    if (acc) model_apply(x, y, c, even_frame);
  endtask

  task automatic do_flush(output int waits);
    logic acc;
    acc = 1'b0; waits = 0;
    flush_req = 1'b1;
    for (int i = 0; i < 40 && !acc; i++) begin
      @(negedge Clk);
      if (flush_done) acc = 1'b1;
      else waits++;
      @(posedge Clk);
      #1;
    end
    flush_req = 1'b0;
    chk("flush_completed", acc, 1'b1);
  endtask

  initial begin
    int w, b, rb, wb, sb, k, sel;
    logic [9:0] rx, ry;
    logic found;

    // Reset state
    Reset = 1'b1; EN = 1'b1; even_frame = 1'b0; flush_req = 1'b0;
    px_valid = 1'b1; px_x = 10'd5; px_y = 10'd2; px_color = 4'd7;
    tick();
    @(negedge Clk);
    chk("rst_px_ready", px_ready, 1'b0);
    chk("rst_step_done", step_done, 1'b1);
    chk("rst_sram_idle", {SRAM_OE_N, SRAM_WE_N, SRAM_ADDRESS, Data_to_SRAM}, {2'b11, 20'h0, 16'h0});
    flush_req = 1'b1;
    #1;
    chk("rst_flush_done", flush_done, 1'b0);
    tick();
    Reset = 1'b0; px_valid = 1'b0; flush_req = 1'b0;
    @(negedge Clk);
    chk("idle_px_ready", px_ready, 1'b1);
    tick();

    // Single pixel with read-modify-write
    rb = rd_cnt; wb = wr_cnt;
    send_px(10'd5, 10'd2, 4'd7, w, b);
    do_flush(w);
    chk("t1_flush_wait", w, 5);
    chk("t1_rd_cycles", rd_cnt - rb, 2);
    chk("t1_rd_addr", last_rd_addr, 20'h40201);
    chk("t1_wr_count", wr_cnt - wb, 1);
    chk("t1_wr_addr", last_wr_addr, 20'h40201);
    chk("t1_wr_data", last_wr_data, 16'h1171);

    // Full-word coalesce, one pixel per clock
    rb = rd_cnt; wb = wr_cnt;
    for (int i = 0; i < 4; i++) begin
      send_px(10'(8 + i), 10'd0, 4'(2 + i), w, b);
      chk($sformatf("t2_hit_wait%0d", i), w, 0);
    end
    do_flush(w);
    chk("t2_flush_wait", w, 3);
    chk("t2_no_read", rd_cnt - rb, 0);
    chk("t2_wr_count", wr_cnt - wb, 1);
    chk("t2_wr_addr", last_wr_addr, 20'h40002);
    chk("t2_wr_data", last_wr_data, 16'h5432);

    // Dropped requests
    rb = rd_cnt; wb = wr_cnt; sb = sd_low_cnt;
    send_px(10'd0, 10'd0, 4'd0, w, b);   chk("t3_drop_wait0", w, 0);
    send_px(10'd640, 10'd0, 4'd3, w, b); chk("t3_drop_wait1", w, 0);
    send_px(10'd0, 10'd480, 4'd3, w, b); chk("t3_drop_wait2", w, 0);
    do_flush(w);
    chk("t3_flush_immediate", w, 0);
    chk("t3_no_sram", {rd_cnt - rb, wr_cnt - wb}, 64'h0);
    chk("t3_step_done_high", sd_low_cnt - sb, 0);

    // Miss stall, then flush winning over a simultaneous pixel
    send_px(10'd0, 10'd0, 4'd2, w, b);
    rb = rd_cnt;
    send_px(10'd4, 10'd0, 4'd3, w, b);
    chk("t4_busy_cycles", b, 4);
    chk("t4_waits", w, 5);
    chk("t4_rd_addr", last_rd_addr, 20'h40000);
    chk("t4_wr_addr", last_wr_addr, 20'h40000);
    chk("t4_wr_data", last_wr_data, 16'h1112);
    px_x = 10'd5; px_y = 10'd0; px_color = 4'd6; px_valid = 1'b1; flush_req = 1'b1;
    @(negedge Clk);
    chk("t4_flush_priority", px_ready, 1'b0);
    tick();
    px_valid = 1'b0;
    do_flush(w);
    chk("t4_flush_data", last_wr_data, 16'h1113);
    chk("t4_flush_addr", last_wr_addr, 20'h40001);

    // Paused grant while a word is pending
    send_px(10'd20, 10'd3, 4'd9, w, b);
    @(negedge Clk);
    chk("t5_en_drop_rule", step_done, 1'b1);
    tick();
    EN = 1'b0;
    px_x = 10'd21; px_y = 10'd3; px_color = 4'hA; px_valid = 1'b1;
    rb = rd_cnt; wb = wr_cnt;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      chk($sformatf("t5_paused%0d", i),
          {px_ready, SRAM_OE_N, SRAM_WE_N, SRAM_ADDRESS, Data_to_SRAM},
          {3'b011, 20'h0, 16'h0});
      tick();
    end
    EN = 1'b1; px_valid = 1'b0;
    chk("t5_no_sram", {rd_cnt - rb, wr_cnt - wb}, 64'h0);
    send_px(10'd21, 10'd3, 4'hA, w, b);
    chk("t5_hit_after_resume", w, 0);
    do_flush(w);
    chk("t5_wr_addr", last_wr_addr, 20'h40305);
    chk("t5_wr_data", last_wr_data, 16'h11A9);

    // Randomized traffic against the image reference
    for (int n = 0; n < 200; n++) begin
      sel = $urandom_range(0, 15);
      if (sel == 0) begin
        do_flush(w);
      end else if (sel == 1) begin
        do_flush(w);
        even_frame = ~even_frame;
      end else if (sel == 2) begin
        @(negedge Clk);
        chk("rand_en_drop_rule", step_done, 1'b1);
        tick();
        EN = 1'b0;
        k = $urandom_range(1, 4);
        repeat (k) tick();
        EN = 1'b1;
      end else begin
        rx = ($urandom_range(0, 9) == 0) ? 10'($urandom_range(636, 700)) : 10'($urandom_range(0, 15));
        ry = ($urandom_range(0, 9) == 0) ? 10'($urandom_range(478, 481)) : 10'($urandom_range(0, 3));
        send_px(rx, ry, 4'($urandom_range(0, 15)), w, b);
      end
    end
    do_flush(w);
    foreach (model[a]) begin
      chk($sformatf("mem_%05h", a), sram.exists(a) ? sram[a] : 16'h1111, model[a]);
    end
    foreach (sram[a]) begin
      chk($sformatf("stray_write_%05h", a), model.exists(a), 1'b1);
    end

    // Reset while the write strobe is active
    even_frame = 1'b0;
    send_px(10'd100, 10'd7, 4'd4, w, b);
    wb = wr_cnt;
    flush_req = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge Clk);
      if (!SRAM_WE_N) found = 1'b1;
      else tick();
    end
    chk("t6_reached_wr", found, 1'b1);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    @(negedge Clk);
    chk("t6_step_done", step_done, 1'b1);
    chk("t6_we_n", SRAM_WE_N, 1'b1);
    chk("t6_idle_flush_done", flush_done, 1'b1);
    tick();
    flush_req = 1'b0;
    repeat (4) tick();
    chk("t6_no_write", wr_cnt - wb, 0);
    send_px(10'd101, 10'd7, 4'd5, w, b);
    do_flush(w);
    chk("t6_mask_cleared", last_wr_data, 16'h1151);
    chk("t6_wr_addr", last_wr_addr, 20'h40719);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/next_frame_writer.md
# next_frame_writer

Pixel-write engine for the next-frame buffer in SRAM. It accepts single-pixel draw requests from the sprite/shape stages and coalesces writes that land in the same 16-bit SRAM word (4 pixels × 4-bit colour index). Each coalesced word is committed with a read-modify-write, or with a plain write when all four nibbles are covered. It shares the SRAM bus with the current-frame controller through the graphics accelerator's `EN`/`step_done` time-slicing, and writes only to the buffer not currently being displayed.

## Interface
Parameters: none (constants in `gfx_pkg`).

Ports:
- `Clk` in 1: system clock.
- `Reset` in 1: synchronous, active-high reset. Clock is `Clk`.
- `EN` in 1: bus grant from the graphics accelerator. When low, the block freezes.
- `even_frame` in 1: displayed-buffer select from the current-frame controller. The target buffer is `~even_frame`.
- `px_valid` in 1: a pixel request is present.
- `px_ready` out 1: the request is accepted this cycle when `px_valid & px_ready`.
- `px_x` in 10: pixel column.
- `px_y` in 10: pixel row.
- `px_color` in 4: palette index; `0` means transparent.
- `flush_req` in 1: level request to commit any pending word (end of draw pass).
- `flush_done` out 1: pending word committed; held high while `flush_req` stays high.
- `step_done` out 1: safe point; the accelerator may drop `EN` on the next edge.
- `Data_to_SRAM` out 16: write data.
- `Data_from_SRAM` in 16: read data.
- `SRAM_WE_N` out 1: write enable, active low (passes through an external 1-cycle synchroniser).
- `SRAM_OE_N` out 1: output enable, active low.
- `SRAM_ADDRESS` out 20: word address.

## Operation
- **Word address:** `{1'b0, ~even_frame, px_y, px_x[9:2]}`.
  - Captured when a pending word is opened.
  - The tag compare uses all 20 bits.
- **Nibble position:** the pixel occupies `data[4*px_x[1:0] +: 4]`.
- **Dropped requests:** requests with `px_color==0`, `px_x>=640` or `px_y>=480` are accepted and dropped. They cause no state change.
- **Pending register:** `pend_addr[19:0]`, `pend_data[15:0]`, `pend_mask[3:0]`.
- **State machine:** states are IDLE, PEND, RD, RD_CAP, WR, WR_HOLD.
  - **IDLE:** `step_done=1`.
    - `flush_req` has priority: assert `flush_done`, `px_ready=0`.
    - Otherwise `px_ready=EN`. An accepted, non-dropped pixel opens a pending word (mask = one bit) → PEND.
  - **PEND:** `step_done=1`.
    - `px_ready = EN & ~flush_req & (hit | drop)`.
    - A hit merges into `pend_data`/`pend_mask`; the later pixel wins on the same nibble.
    - On a miss (valid, non-dropped, different address) or on `flush_req` → WR if `pend_mask==4'hF`, else RD. The missed request is not accepted.
  - **RD:** `OE_N=0`, address = `pend_addr` → RD_CAP.
  - **RD_CAP:** `OE_N=0`, address held. Register `merged = (Data_from_SRAM & ~M) | (pend_data & M)`, where `M` is the mask expanded to nibbles → WR.
  - **WR:** `WE_N=0`, address and `Data_to_SRAM=merged` (or `pend_data` on the full-mask path) → WR_HOLD.
  - **WR_HOLD:** `WE_N=1` (the synchroniser keeps the write active), address and data held. Clear mask → IDLE.
- `step_done=0` in RD through WR_HOLD.
- **When `EN` is low:**
  - The state and pending register hold.
  - `px_ready=0`.
  - All SRAM outputs are inactive.
  - `flush_done` still reflects state.
- The accelerator drops `EN` only after a cycle with `step_done=1`. The bench asserts this rule.
- **SRAM outputs when inactive:** `OE_N=1`, `WE_N=1`, `ADDRESS=20'h0`, `Data_to_SRAM=16'h0`.

## Timing
- **Reset:**
  - state IDLE, `pend_mask=0`.
  - `px_ready=0` and `flush_done=0` during the Reset cycle.
  - `step_done=1`.
  - SRAM outputs inactive.
- Reset mid-RMW abandons the write. No further `WE_N` pulse is issued.
- **Read latency:** `Data_from_SRAM` is valid one `Clk` after the address is presented with `OE_N=0`. It is sampled in RD_CAP.
- **Commit length:**
  - Partial word: 4 cycles (RD, RD_CAP, WR, WR_HOLD).
  - Full word: 2 cycles (WR, WR_HOLD).
- **Hits:** a hit is accepted every cycle in PEND (throughput 1 pixel/clk).
- **Misses:** a miss stalls `px_ready` for the commit length. It is accepted in IDLE on the cycle after WR_HOLD.
- **Flush:** `flush_done` rises the cycle after WR_HOLD, or immediately if the block is idle.
- **Simultaneous `px_valid` and `flush_req`:** flush wins and the pixel waits.
- **Buffer swap:** `even_frame` toggling while in PEND does not retarget the open word. The accelerator guarantees a flush precedes the buffer swap.

## Structure
- **`gfx_pkg`:**
  - state enum `nfw_state_t`
  - `FRAME_W=640`, `FRAME_H=480`
  - `TRANSPARENT=4'h0`, `BG_COLOR=4'h1`
  - `SRAM_IDLE_ADDR=20'h0`
- **Sub-module `pixel_word_merge`:** combinational. Inputs are base word, mask, and pend data; output is the merged word. It is reused by the hit merge and RD_CAP.

## Test plan
- **Single pixel:** `even_frame=0`, pixel (5,2,7), then flush. SRAM returns `16'h1111`. Required: read at `20'h40201`, then write `16'h1171` at `20'h40201`, then `flush_done=1`.
- **Full-word coalesce:** pixels x=8..11, y=0, colours 2,3,4,5 on consecutive clocks, then flush. Required: `OE_N` never low; single write `16'h5432` at `20'h40002`.
- **Dropped requests:** colour 0 at (0,0), then (640,0,3), then (0,480,3). Required: all accepted, no SRAM activity, `step_done` stays 1.
- **Miss stall:** (0,0,2), then (4,0,3). Required: second request stalled 4 cycles (RD..WR_HOLD on `20'h40000`), then accepted in IDLE.
- **Paused grant:** `EN` low for 10 cycles while in PEND. Required: `px_ready=0`, SRAM outputs inactive, pending word intact. After re-enable, flush writes the correct data.
- **Reset during WR:** `Reset` pulsed in WR. Required: next cycle IDLE, `WE_N=1`, mask 0, `step_done=1`.
